// File: rtl/kb_text_ctrl.sv
// PS/2 byte sequencer: parses make/break/E0 prefixes, tracks Shift, drives the scan LUT, then writes text or moves the cursor.
// Latency: tick -> lut_scan next cycle -> write/cursor the cycle after; ticks arriving while busy (LOOKUP) are dropped, no backpressure.
module kb_text_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    output logic [7:0]        lut_scan,
    input  logic [7:0]        lut_ascii,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cur_x,
    output logic [5:0]        cur_y,
    output logic              shift,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_LOOKUP} state_t;

    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [5:0] Y_MAX = 6'(ROWS - 1);
    localparam logic [7:0] COLS8 = 8'(COLS);

    state_t            state;
    logic [5:0]        y_wrap;
    logic [6:0]        bs_x;
    logic [5:0]        bs_y;
    logic [7:0]        tab_x;
    logic [ADDR_W-1:0] addr_cur;
    logic [ADDR_W-1:0] addr_bs;
    logic              printable;
    logic              is_lower;
    logic              mapped;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [6:0] x, input logic [5:0] y);
        return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
    endfunction

    always_comb begin
        y_wrap    = (cur_y == Y_MAX) ? 6'd0 : cur_y + 6'd1;
        bs_x      = cur_x;
        bs_y      = cur_y;
        if (cur_x != 7'd0) begin
            bs_x = cur_x - 7'd1;
        end else if (cur_y != 6'd0) begin
            bs_x = X_MAX;
            bs_y = cur_y - 6'd1;
        end
        tab_x     = {1'b0, cur_x | 7'd7} + 8'd1;
        addr_cur  = addr_of(cur_x, cur_y);
        addr_bs   = addr_of(bs_x, bs_y);
        printable = (lut_ascii >= 8'h20) && (lut_ascii <= 8'h7E);
        is_lower  = (lut_ascii >= 8'h61) && (lut_ascii <= 8'h7A);
        // The LUT reports unmapped codes as 'a'; only scan 1C is a genuine 'a'.
        mapped    = !((lut_ascii == 8'h61) && (lut_scan != 8'h1C));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            we       <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            lut_scan <= 8'h00;
            cur_x    <= 7'd0;
            cur_y    <= 6'd0;
            shift    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            we   <= 1'b0;
            busy <= 1'b0;
            case (state)
                S_IDLE, S_EXT: begin
                    if (rx_done_tick) begin
                        if (rx_data == 8'hE0) begin
                            state <= S_EXT;
                        end else if (rx_data == 8'hF0) begin
                            state <= S_BRK;
                        end else if (rx_data == 8'h12 || rx_data == 8'h59) begin
                            shift <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            lut_scan <= rx_data;
                            busy     <= 1'b1;
                            state    <= S_LOOKUP;
                        end
                    end
                end
                S_BRK: begin
                    if (rx_done_tick) begin
                        if (rx_data == 8'h12 || rx_data == 8'h59) shift <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    if (mapped) begin
                        if (printable) begin
                            we      <= 1'b1;
                            wr_addr <= addr_cur;
                            wr_data <= (shift && is_lower) ? lut_ascii - 8'h20 : lut_ascii;
                            if (cur_x == X_MAX) begin
                                cur_x <= 7'd0;
                                cur_y <= y_wrap;
                            end else begin
                                cur_x <= cur_x + 7'd1;
                            end
                        end else begin
                            case (lut_ascii)
                                8'h0A: begin
                                    cur_x <= 7'd0;
                                    cur_y <= y_wrap;
                                end
                                8'h0D: cur_x <= 7'd0;
                                8'h08: begin
                                    cur_x   <= bs_x;
                                    cur_y   <= bs_y;
                                    we      <= 1'b1;
                                    wr_addr <= addr_bs;
                                    wr_data <= 8'h20;
                                end
                                8'h09: begin
                                    if (tab_x >= COLS8) begin
                                        cur_x <= 7'd0;
                                        cur_y <= y_wrap;
                                    end else begin
                                        cur_x <= tab_x[6:0];
                                    end
                                end
                                8'h11: if (cur_y != 6'd0) cur_y <= cur_y - 6'd1;
                                8'h13: if (cur_y != Y_MAX) cur_y <= cur_y + 6'd1;
                                8'h12: if (cur_x != 7'd0) cur_x <= cur_x - 7'd1;
                                8'h14: if (cur_x != X_MAX) cur_x <= cur_x + 7'd1;
                                8'h7F: begin
                                    we      <= 1'b1;
                                    wr_addr <= addr_cur;
                                    wr_data <= 8'h20;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kb_text_ctrl.sv
// Scoreboard bench for kb_text_ctrl: a reference model predicts writes and cursor/shift state per PS/2 byte.
module tb_kb_text_ctrl;

    logic        clk;
    logic        resetn;
    logic        rx_done_tick;
    logic [7:0]  rx_data;
    logic [7:0]  lut_scan;
    logic [7:0]  lut_ascii;
    logic        we;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cur_x;
    logic [5:0]  cur_y;
    logic        shift;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [20:0] exp_q[$];
    int          mx, my;
    bit          mshift, mbrk;

    kb_text_ctrl #(.COLS(80), .ROWS(60), .ADDR_W(13)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_done_tick(rx_done_tick),
        .rx_data     (rx_data),
        .lut_scan    (lut_scan),
        .lut_ascii   (lut_ascii),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .shift       (shift),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lut_fn(input logic [7:0] s);
        case (s)
            8'h1C: return 8'h61;
            8'h32: return 8'h62;
            8'h16: return 8'h31;
            8'h29: return 8'h20;
            8'h5A: return 8'h0A;
            8'h6C: return 8'h0D;
            8'h66: return 8'h08;
            8'h0D: return 8'h09;
            8'h75: return 8'h11;
            8'h72: return 8'h13;
            8'h6B: return 8'h12;
            8'h74: return 8'h14;
            8'h71: return 8'h7F;
            8'h76: return 8'h1B;
            default: return 8'h61;
        endcase
    endfunction

    assign lut_ascii = lut_fn(lut_scan);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input int pos, input logic [7:0] d);
        logic [12:0] a;
        a = 13'(pos);
        exp_q.push_back({a, d});
    endtask

    task automatic model_action(input logic [7:0] a, input logic [7:0] scan);
        int pos;
        pos = my * 80 + mx;
        if (a == 8'h61 && scan != 8'h1C) return;
        if (a >= 8'h20 && a <= 8'h7E) begin
            push_wr(pos, (mshift && a >= 8'h61 && a <= 8'h7A) ? a - 8'h20 : a);
            pos = (pos + 1) % 4800;
            mx = pos % 80;
            my = pos / 80;
        end else begin
            case (a)
                8'h0A: begin mx = 0; my = (my + 1) % 60; end
                8'h0D: mx = 0;
                8'h08: begin
                    if (pos > 0) pos = pos - 1;
                    mx = pos % 80;
                    my = pos / 80;
                    push_wr(pos, 8'h20);
                end
                8'h09: begin
                    if ((mx | 7) + 1 >= 80) begin mx = 0; my = (my + 1) % 60; end
                    else mx = (mx | 7) + 1;
                end
                8'h11: if (my > 0) my--;
                8'h13: if (my < 59) my++;
                8'h12: if (mx > 0) mx--;
                8'h14: if (mx < 79) mx++;
                8'h7F: push_wr(pos, 8'h20);
                default: ;
            endcase
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (mbrk) begin
            if (b == 8'h12 || b == 8'h59) mshift = 0;
            mbrk = 0;
        end else if (b == 8'hF0) begin
            mbrk = 1;
        end else if (b == 8'h12 || b == 8'h59) begin
            mshift = 1;
        end else if (b != 8'hE0) begin
            model_action(lut_fn(b), b);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mshift = 0; mbrk = 0;
        exp_q.delete();
    endtask

    // Drives a one-cycle tick; returns at the negedge right after the accepting edge.
    task automatic send(input logic [7:0] b, input bit do_model);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        if (do_model) model_byte(b);
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic check_cursor(input string tag);
        chk({tag, ".x"}, 32'(cur_x), 32'(mx));
        chk({tag, ".y"}, 32'(cur_y), 32'(my));
        chk({tag, ".shift"}, 32'(shift), 32'(mshift));
    endtask

    task automatic key(input logic [7:0] b, input string tag);
        send(b, 1'b1);
        repeat (2) @(negedge clk);
        check_cursor(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    always @(negedge clk) begin
        if (resetn && we) begin
            if (exp_q.size() == 0) begin
                chk("we_unexpected", 32'(we), 32'd0);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[20:8]));
                chk("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
    end

    initial begin
        resetn       = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst.we", 32'(we), 0);
        chk("rst.wr_addr", 32'(wr_addr), 0);
        chk("rst.wr_data", 32'(wr_data), 0);
        chk("rst.lut_scan", 32'(lut_scan), 0);
        chk("rst.busy", 32'(busy), 0);
        check_cursor("rst");
        resetn = 1'b1;

        // Latency: tick in cycle 0, lut_scan/busy in cycle 1, write in cycle 2.
        send(8'h1C, 1'b1);
        chk("lat.busy", 32'(busy), 1);
        chk("lat.lut_scan", 32'(lut_scan), 32'h1C);
        chk("lat.we_c1", 32'(we), 0);
        @(negedge clk);
        chk("lat.we_c2", 32'(we), 1);
        chk("lat.busy_c2", 32'(busy), 0);
        check_cursor("lat");

        key(8'h12, "shift_on");
        key(8'h1C, "upper_a");
        key(8'h16, "shift_digit");
        key(8'hF0, "brk");
        key(8'h12, "shift_off");
        key(8'h1C, "lower_a");
        key(8'h32, "b");
        key(8'h29, "space");
        key(8'h0D, "tab");
        key(8'h71, "delete");
        key(8'h6B, "left");
        key(8'h5A, "newline");
        key(8'h59, "rshift_on");
        key(8'h32, "upper_b");
        key(8'hE0, "ext_rshift");
        key(8'hF0, "ext_brk");
        key(8'h59, "rshift_off");
        key(8'h05, "unmapped");
        key(8'h76, "esc");
        key(8'hF0, "brk_a");
        key(8'h1C, "brk_a_done");

        // A tick arriving while in LOOKUP is dropped.
        send(8'h1C, 1'b1);
        chk("drop.busy", 32'(busy), 1);
        rx_data      = 8'h16;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
        check_cursor("drop");

        // A tick in cycle 2 is accepted back to back.
        send(8'h1C, 1'b1);
        send(8'h16, 1'b1);
        repeat (2) @(negedge clk);
        check_cursor("b2b");

        do_reset();
        for (int i = 0; i < 5; i++) begin
            key(8'hE0, "ext");
            key(8'h74, "right");
        end
        key(8'hE0, "ext");
        key(8'h75, "up_sat");
        key(8'hE0, "ext");
        key(8'h72, "down");
        key(8'h6C, "home");
        key(8'h66, "bs_wrap");
        key(8'h6C, "home2");
        key(8'h66, "bs_origin");
        for (int i = 0; i < 10; i++) key(8'h0D, "tab_run");

        do_reset();
        for (int i = 0; i < 60; i++) begin
            send(8'hE0, 1'b1);
            send(8'h72, 1'b1);
        end
        for (int i = 0; i < 80; i++) begin
            send(8'hE0, 1'b1);
            send(8'h74, 1'b1);
        end
        repeat (2) @(negedge clk);
        check_cursor("corner");
        key(8'h16, "corner_wrap");
        key(8'hE0, "ext");
        key(8'h6B, "left_sat");

        // Reset during LOOKUP cancels the pending write.
        send(8'h1C, 1'b0);
        resetn = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_lookup.we", 32'(we), 0);
        chk("rst_lookup.busy", 32'(busy), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check_cursor("rst_lookup");

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
